// File: rtl/seg7_signed_scan_if.sv
// Pin-side bus of seg7_signed_scan: signed value and load request in,
// busy flag, scanned segment/anode pins and FSM state out.
interface seg7_signed_scan_if #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 4
) ();
    // Handshake: load is sampled on a rising edge only while busy is low; a
    // load seen while busy is high (the commit cycle included) is dropped.
    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              busy;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              dp;
    logic [1:0]        state_dbg;

    modport master (
        output data_in, load,
        input  busy, seg, an, dp, state_dbg
    );

    modport slave (
        input  data_in, load,
        output busy, seg, an, dp, state_dbg
    );
endinterface

// File: rtl/seg7_signed_scan.sv
// Signed value -> sign + BCD by sequential double-dabble, scanned over DIGITS
// common-anode digits. Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg7_signed_scan #(
    parameter int DIGITS  = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_MAX = 65000
) (
    input logic               clk,
    input logic               rst_n,
    seg7_signed_scan_if.slave bus
);
    localparam int NM     = DIGITS - 1;
    localparam int BW     = 4 * NM;
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int STEP_W = $clog2(DATA_W);
    localparam int CNT_W  = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int LW     = 40;

    function automatic logic [LW-1:0] pow10(input int n);
        logic [LW-1:0] r;
        r = LW'(1);
        for (int i = 0; i < n; i++) r = r * LW'(10);
        return r;
    endfunction

    localparam logic [LW-1:0] LIMIT = pow10(NM);

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    digit_code = 7'b1000000;
            4'd1:    digit_code = 7'b1111001;
            4'd2:    digit_code = 7'b0100100;
            4'd3:    digit_code = 7'b0110000;
            4'd4:    digit_code = 7'b0011001;
            4'd5:    digit_code = 7'b0010010;
            4'd6:    digit_code = 7'b0000010;
            4'd7:    digit_code = 7'b1111000;
            4'd8:    digit_code = 7'b0000000;
            4'd9:    digit_code = 7'b0010000;
            default: digit_code = 7'b1111111;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

    state_t              state, state_nxt;
    logic                latch, step, commit;
    logic [STEP_W-1:0]   step_cnt;
    logic [DATA_W-1:0]   sh, mag_in;
    logic [BW-1:0]       bcd, bcd_adj, disp_bcd;
    logic [BW+DATA_W-1:0] dd_nxt;
    logic                sign_r, ovf_r, disp_sign, disp_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: if (bus.load) begin
                latch     = 1'b1;
                state_nxt = CONV;
            end
            CONV: begin
                step = 1'b1;
                if (step_cnt == STEP_W'(DATA_W - 1)) state_nxt = DONE;
            end
            DONE: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Two's-complement negate in DATA_W bits leaves the most negative value as
    // its own unsigned magnitude, e.g. 8'h80 -> 128.
    assign mag_in = bus.data_in[DATA_W-1] ? (~bus.data_in + DATA_W'(1)) : bus.data_in;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NM; i++)
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        dd_nxt = {bcd_adj, sh} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh        <= '0;
            bcd       <= '0;
            step_cnt  <= '0;
            sign_r    <= 1'b0;
            ovf_r     <= 1'b0;
            disp_sign <= 1'b0;
            disp_bcd  <= '0;
            disp_ovf  <= 1'b0;
        end else begin
            if (latch) begin
                sh       <= mag_in;
                bcd      <= '0;
                step_cnt <= '0;
                sign_r   <= bus.data_in[DATA_W-1];
                ovf_r    <= {{(LW-DATA_W){1'b0}}, mag_in} >= LIMIT;
            end
            if (step) begin
                bcd      <= dd_nxt[BW+DATA_W-1:DATA_W];
                sh       <= dd_nxt[DATA_W-1:0];
                step_cnt <= step_cnt + STEP_W'(1);
            end
            if (commit) begin
                disp_sign <= sign_r;
                disp_bcd  <= bcd;
                disp_ovf  <= ovf_r;
            end
        end
    end

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             cnt_wrap;
    logic [6:0]       codes [0:(1<<IDX_W)-1];

    always_comb begin
        for (int i = 0; i < (1 << IDX_W); i++) codes[i] = 7'b1111111;
        for (int i = 0; i < NM; i++) begin
            codes[i] = disp_ovf ? 7'b0000110 : digit_code(disp_bcd[4*i +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (!disp_ovf && i != 0 && (disp_bcd >> (4*i)) == '0) codes[i] = 7'b1111111;
`endif
        end
        codes[NM] = disp_sign ? 7'b0111111 : 7'b1111111;
    end

    assign cnt_wrap = (cnt == CNT_W'(CNT_MAX));
    assign idx_nxt  = !cnt_wrap ? idx :
                      (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);

    // seg is registered from the next index so it lands with its anode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            bus.an  <= ~DIGITS'(1);
            bus.seg <= 7'b1000000;
        end else begin
            cnt     <= cnt_wrap ? '0 : cnt + CNT_W'(1);
            idx     <= idx_nxt;
            bus.an  <= ~(DIGITS'(1) << idx_nxt);
            bus.seg <= codes[idx_nxt];
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.dp        = 1'b1;
    assign bus.state_dbg = state;
endmodule
